// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt arbiter.
// Synchronises the external interrupt lines and reads Status/Cause/EPC, with a
// bypass from a pending WB-stage mtc0. For the instruction in MEM it raises
// exception or eret events, then holds flush_o and new_pc_o for FLUSH_CYCLES
// cycles. It also issues one-cycle exception-entry and eret strobes to CP0.
module cp0_exc_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_raw_i,
  output logic [5:0]  int_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic        mem_syscall_i,
  input  logic        mem_eret_i,
  input  logic        mem_ri_i,
  input  logic        mem_ov_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        exc_we_o,
  output logic [4:0]  exc_code_o,
  output logic        exc_bd_o,
  output logic [31:0] exc_epc_o,
  output logic        eret_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_RI  = 5'd10;
  localparam logic [4:0] CODE_OV  = 5'd12;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [5:0]  int_s1;

  logic [31:0] st;
  logic [31:0] ca;
  logic [31:0] epc_eff;
  logic        int_pend;
  logic        exc_hit;
  logic        eret_hit;
  logic [4:0]  code;
  logic [31:0] epc_calc;
  logic        unused_bits;

  // Effective CP0 view with WB mtc0 bypass, and exception priority resolution.
  always_comb begin
    st = status_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
    epc_eff = epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) epc_eff = wb_cp0_data_i;
    ca = cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];

    int_pend = st[0] & ~st[1] & (|(ca[15:8] & st[15:8]));

    exc_hit = 1'b1;
    code    = CODE_INT;
    if (int_pend)           code = CODE_INT;
    else if (mem_ri_i)      code = CODE_RI;
    else if (mem_syscall_i) code = CODE_SYS;
    else if (mem_ov_i)      code = CODE_OV;
    else                    exc_hit = 1'b0;

    eret_hit = ~exc_hit & mem_eret_i;
    epc_calc = mem_in_delay_i ? (mem_pc_i - 32'd4) : mem_pc_i;
  end

  assign unused_bits = ^{st[31:16], st[7:2], ca[31:16], ca[7:0]};

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_s1 <= '0;
      int_o  <= '0;
    end else begin
      int_s1 <= int_raw_i;
      int_o  <= int_s1;
    end
  end

  // Event capture in IDLE, then flush hold; strobes self-clear after one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      exc_we_o   <= 1'b0;
      exc_code_o <= '0;
      exc_bd_o   <= 1'b0;
      exc_epc_o  <= '0;
      eret_o     <= 1'b0;
      flush_o    <= 1'b0;
      new_pc_o   <= '0;
    end else begin
      exc_we_o <= 1'b0;
      eret_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid_i && (exc_hit || eret_hit)) begin
            state   <= FLUSH;
            cnt     <= CNT_INIT;
            flush_o <= 1'b1;
            if (exc_hit) begin
              exc_we_o   <= 1'b1;
              exc_code_o <= code;
              exc_bd_o   <= mem_in_delay_i;
              exc_epc_o  <= epc_calc;
              new_pc_o   <= EXC_VECTOR;
            end else begin
              eret_o   <= 1'b1;
              new_pc_o <= epc_eff;
            end
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state   <= IDLE;
            flush_o <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: two instances (FLUSH_CYCLES=1 and 3) share
// all inputs; expected outputs are queued with each stimulus step and
// compared one cycle later.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_raw_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delay_i;
  logic        mem_syscall_i;
  logic        mem_eret_i;
  logic        mem_ri_i;
  logic        mem_ov_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  logic [5:0]  d1_int, d3_int;
  logic        d1_we, d3_we;
  logic [4:0]  d1_code, d3_code;
  logic        d1_bd, d3_bd;
  logic [31:0] d1_epc, d3_epc;
  logic        d1_eret, d3_eret;
  logic        d1_flush, d3_flush;
  logic [31:0] d1_npc, d3_npc;

  always #5 clk = ~clk;

  cp0_exc_unit #(.EXC_VECTOR(32'h00000020), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .int_raw_i(int_raw_i), .int_o(d1_int),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delay_i(mem_in_delay_i),
    .mem_syscall_i(mem_syscall_i), .mem_eret_i(mem_eret_i), .mem_ri_i(mem_ri_i),
    .mem_ov_i(mem_ov_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .exc_we_o(d1_we), .exc_code_o(d1_code), .exc_bd_o(d1_bd), .exc_epc_o(d1_epc),
    .eret_o(d1_eret), .flush_o(d1_flush), .new_pc_o(d1_npc)
  );

  cp0_exc_unit #(.EXC_VECTOR(32'h00000020), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .int_raw_i(int_raw_i), .int_o(d3_int),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delay_i(mem_in_delay_i),
    .mem_syscall_i(mem_syscall_i), .mem_eret_i(mem_eret_i), .mem_ri_i(mem_ri_i),
    .mem_ov_i(mem_ov_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .exc_we_o(d3_we), .exc_code_o(d3_code), .exc_bd_o(d3_bd), .exc_epc_o(d3_epc),
    .eret_o(d3_eret), .flush_o(d3_flush), .new_pc_o(d3_npc)
  );

  // Output selectors; instance 3 uses the same codes offset by 8.
  localparam int O_INT = 0, O_WE = 1, O_CODE = 2, O_BD = 3;
  localparam int O_EPC = 4, O_ERET = 5, O_FL = 6, O_NPC = 7;
  localparam int D1 = 0, D3 = 8;

  typedef struct {
    string       tag;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] obs(input int id);
    case (id)
      0:  return {26'd0, d1_int};
      1:  return {31'd0, d1_we};
      2:  return {27'd0, d1_code};
      3:  return {31'd0, d1_bd};
      4:  return d1_epc;
      5:  return {31'd0, d1_eret};
      6:  return {31'd0, d1_flush};
      7:  return d1_npc;
      8:  return {26'd0, d3_int};
      9:  return {31'd0, d3_we};
      10: return {27'd0, d3_code};
      11: return {31'd0, d3_bd};
      12: return d3_epc;
      13: return {31'd0, d3_eret};
      14: return {31'd0, d3_flush};
      15: return d3_npc;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int id, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.id = id; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic exp_exc(input string tag, input int b, input logic [4:0] code,
                         input logic bd, input logic [31:0] epc);
    push({tag, "_we"},    b + O_WE,   32'd1);
    push({tag, "_code"},  b + O_CODE, {27'd0, code});
    push({tag, "_bd"},    b + O_BD,   {31'd0, bd});
    push({tag, "_epc"},   b + O_EPC,  epc);
    push({tag, "_eret"},  b + O_ERET, 32'd0);
    push({tag, "_flush"}, b + O_FL,   32'd1);
    push({tag, "_npc"},   b + O_NPC,  32'h00000020);
  endtask

  task automatic exp_quiet(input string tag, input int b);
    push({tag, "_we"},    b + O_WE,   32'd0);
    push({tag, "_eret"},  b + O_ERET, 32'd0);
    push({tag, "_flush"}, b + O_FL,   32'd0);
  endtask

  task automatic exp_zero(input string tag, input int b);
    for (int i = 0; i < 8; i++) push(tag, b + i, 32'd0);
  endtask

  // Advance one clock, then compare every queued expectation.
  task automatic step();
    exp_t e;
    logic [31:0] o;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.id);
      n_cmp++;
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_in();
    mem_valid_i = 1'b0; mem_pc_i = '0; mem_in_delay_i = 1'b0;
    mem_syscall_i = 1'b0; mem_eret_i = 1'b0; mem_ri_i = 1'b0; mem_ov_i = 1'b0;
    status_i = '0; cause_i = '0; epc_i = '0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = '0; wb_cp0_data_i = '0;
  endtask

  initial begin
    rst = 1'b1;
    int_raw_i = '0;
    clear_in();

    // Reset state
    idle(1);
    exp_zero("rst1", D1);
    exp_zero("rst3", D3);
    step();
    rst = 1'b0;

    // 1: interrupt through synchroniser, then exception entry
    int_raw_i = 6'b000001;
    push("t1_sync1", D1 + O_INT, 32'd0);
    step();
    push("t1_sync2", D1 + O_INT, 32'd1);
    push("t1_sync2_3", D3 + O_INT, 32'd1);
    step();
    status_i = 32'h00000401; cause_i = 32'h00000400;
    mem_valid_i = 1'b1; mem_pc_i = 32'h100;
    exp_exc("t1_d1", D1, 5'd0, 1'b0, 32'h100);
    exp_exc("t1_d3", D3, 5'd0, 1'b0, 32'h100);
    step();
    clear_in(); int_raw_i = '0;
    exp_quiet("t1_end1", D1);
    push("t1_fl3a", D3 + O_FL, 32'd1);
    push("t1_we3a", D3 + O_WE, 32'd0);
    step();
    push("t1_fl3b", D3 + O_FL, 32'd1);
    push("t1_npc3b", D3 + O_NPC, 32'h20);
    step();
    push("t1_fl3c", D3 + O_FL, 32'd0);
    step();
    idle(2);

    // 2: syscall in a delay slot
    mem_valid_i = 1'b1; mem_syscall_i = 1'b1; mem_in_delay_i = 1'b1; mem_pc_i = 32'h204;
    exp_exc("t2_d1", D1, 5'd8, 1'b1, 32'h200);
    exp_exc("t2_d3", D3, 5'd8, 1'b1, 32'h200);
    step();
    clear_in();
    exp_quiet("t2_end1", D1);
    step();
    idle(4);

    // 3: eret with EPC bypassed from WB mtc0
    mem_valid_i = 1'b1; mem_eret_i = 1'b1; mem_pc_i = 32'h300; epc_i = 32'h50;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80;
    push("t3_eret", D1 + O_ERET, 32'd1);
    push("t3_npc", D1 + O_NPC, 32'h80);
    push("t3_we", D1 + O_WE, 32'd0);
    push("t3_flush", D1 + O_FL, 32'd1);
    push("t3_code_hold", D1 + O_CODE, 32'd8);
    push("t3_epc_hold", D1 + O_EPC, 32'h200);
    push("t3_bd_hold", D1 + O_BD, 32'd1);
    push("t3_eret3", D3 + O_ERET, 32'd1);
    push("t3_npc3", D3 + O_NPC, 32'h80);
    step();
    clear_in();
    exp_quiet("t3_end1", D1);
    push("t3_eret3_off", D3 + O_ERET, 32'd0);
    step();
    idle(4);

    // 4: ri+ov priority, flush length 3, syscall ignored during flush
    mem_valid_i = 1'b1; mem_ri_i = 1'b1; mem_ov_i = 1'b1; mem_pc_i = 32'h400;
    exp_exc("t4_d1", D1, 5'd10, 1'b0, 32'h400);
    exp_exc("t4_d3", D3, 5'd10, 1'b0, 32'h400);
    step();
    mem_ri_i = 1'b0; mem_ov_i = 1'b0; mem_syscall_i = 1'b1; mem_pc_i = 32'h500;
    exp_quiet("t4_a1_d1", D1);
    push("t4_a1_fl3", D3 + O_FL, 32'd1);
    push("t4_a1_we3", D3 + O_WE, 32'd0);
    step();
    exp_exc("t4_a2_d1", D1, 5'd8, 1'b0, 32'h500);
    push("t4_a2_fl3", D3 + O_FL, 32'd1);
    push("t4_a2_we3", D3 + O_WE, 32'd0);
    push("t4_a2_code3", D3 + O_CODE, 32'd10);
    step();
    exp_quiet("t4_a3_d1", D1);
    push("t4_a3_fl3", D3 + O_FL, 32'd0);
    push("t4_a3_we3", D3 + O_WE, 32'd0);
    push("t4_a3_code3", D3 + O_CODE, 32'd10);
    step();
    clear_in();
    exp_quiet("t4_a4_d3", D3);
    step();
    idle(3);

    // 5: masked interrupts produce nothing
    mem_valid_i = 1'b1; mem_pc_i = 32'h600; cause_i = 32'h400; status_i = 32'h403;
    exp_quiet("t5_exl1", D1); exp_quiet("t5_exl3", D3);
    step();
    status_i = 32'h400;
    exp_quiet("t5_ie0_1", D1); exp_quiet("t5_ie0_3", D3);
    step();
    status_i = 32'h401; mem_valid_i = 1'b0;
    exp_quiet("t5_bub1", D1); exp_quiet("t5_bub3", D3);
    step();
    mem_valid_i = 1'b1; wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h403;
    exp_quiet("t5_stbyp1", D1); exp_quiet("t5_stbyp3", D3);
    step();
    // Cause IP[1:0] bypass makes an interrupt pending
    clear_in();
    mem_valid_i = 1'b1; mem_pc_i = 32'h700; status_i = 32'h101;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h100;
    exp_exc("t5_cabyp1", D1, 5'd0, 1'b0, 32'h700);
    exp_exc("t5_cabyp3", D3, 5'd0, 1'b0, 32'h700);
    step();
    clear_in();
    idle(4);
    // Interrupt beats eret; EPC comes from the eret's PC
    mem_valid_i = 1'b1; mem_eret_i = 1'b1; mem_pc_i = 32'h800;
    status_i = 32'h401; cause_i = 32'h400; epc_i = 32'h44;
    exp_exc("t5_interet1", D1, 5'd0, 1'b0, 32'h800);
    exp_exc("t5_interet3", D3, 5'd0, 1'b0, 32'h800);
    step();
    clear_in();
    idle(4);

    // 6: reset in the second flush cycle
    int_raw_i = 6'h3F;
    idle(2);
    push("t6_int3", D3 + O_INT, 32'h3F);
    step();
    mem_valid_i = 1'b1; mem_syscall_i = 1'b1; mem_pc_i = 32'h900;
    exp_exc("t6_d1", D1, 5'd8, 1'b0, 32'h900);
    exp_exc("t6_d3", D3, 5'd8, 1'b0, 32'h900);
    step();
    clear_in();
    push("t6_fl3", D3 + O_FL, 32'd1);
    step();
    rst = 1'b1;
    exp_zero("t6_rst1", D1);
    exp_zero("t6_rst3", D3);
    step();
    rst = 1'b0; int_raw_i = '0;
    exp_quiet("t6_post3", D3);
    step();
    mem_valid_i = 1'b1; mem_syscall_i = 1'b1; mem_pc_i = 32'hA00;
    exp_exc("t6_sys1", D1, 5'd8, 1'b0, 32'hA00);
    exp_exc("t6_sys3", D3, 5'd8, 1'b0, 32'hA00);
    step();
    clear_in();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Exception/interrupt arbiter and the consumer side of the CP0 register block.
- Synchronises external interrupt lines and drives the CP0 int_i port.
- Reads CP0 Status/Cause/EPC, with bypass from a pending WB-stage mtc0.
- Evaluates exceptions for the instruction in MEM and issues pipeline flush, redirect PC and CP0 exception-update commands.
- Sits between the MEM stage, the CP0 register block and pipeline control.

Parameters:
EXC_VECTOR, 32'h00000020, handler entry PC for all exceptions and interrupts
FLUSH_CYCLES, 1, number of cycles flush_o is held high per event (legal range 1..7)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
int_raw_i  in  6  asynchronous external interrupt lines
int_o  out  6  synchronised interrupts, to CP0 int_i
mem_valid_i  in  1  MEM holds a real instruction
mem_pc_i  in  32  PC of the MEM instruction
mem_in_delay_i  in  1  MEM instruction is in a branch delay slot
mem_syscall_i  in  1  syscall
mem_eret_i  in  1  eret
mem_ri_i  in  1  reserved/invalid instruction
mem_ov_i  in  1  arithmetic overflow
status_i  in  32  CP0 Status
cause_i  in  32  CP0 Cause
epc_i  in  32  CP0 EPC
wb_cp0_we_i  in  1  pending mtc0 in WB
wb_cp0_waddr_i  in  5  mtc0 target register
wb_cp0_data_i  in  32  mtc0 data
exc_we_o  out  1  one-cycle CP0 exception-entry write strobe
exc_code_o  out  5  ExcCode, to Cause[6:2]
exc_bd_o  out  1  BD bit, to Cause[31]
exc_epc_o  out  32  value to write into EPC
eret_o  out  1  one-cycle strobe: CP0 clears Status.EXL
flush_o  out  1  flush IF..MEM
new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Reset: all outputs are 0, the synchroniser flops are 0, and the FSM is in IDLE. Reset asserted mid-flush aborts the flush and returns to IDLE at the next edge; nothing is held over.
- Synchroniser: two flops per line. A change on int_raw_i appears on int_o 2 cycles later.
- Effective registers (combinational):
  - st = wb_cp0_data_i if wb_cp0_we_i and waddr=12, else status_i.
  - epc = wb_cp0_data_i if wb_cp0_we_i and waddr=14, else epc_i.
  - ca = cause_i, with bits [9:8] replaced by wb_cp0_data_i[9:8] if wb_cp0_we_i and waddr=13.
- Interrupt pending: st[0]=1 and st[1]=0 and (ca[15:8] & st[15:8]) != 0.
- Detection (IDLE only, requires mem_valid_i=1). Priority, highest first:
  1. interrupt, code 0
  2. mem_ri_i, code 10
  3. mem_syscall_i, code 8
  4. mem_ov_i, code 12
  5. mem_eret_i, no code; handled as eret
- Exception event:
  - At the next edge: exc_we_o=1 for 1 cycle, exc_code_o=code.
  - exc_bd_o=mem_in_delay_i; exc_epc_o = mem_pc_i - 4 if in delay slot, else mem_pc_i. Use 32-bit wrap arithmetic.
  - If st[1]=1 (EXL already set) for a non-interrupt exception: exc_we_o still pulses with exc_code_o, but the EPC/BD fields are still driven. CP0 owns the EXL gating of EPC writes.
  - new_pc_o=EXC_VECTOR, flush_o=1.
- Eret event: at the next edge, eret_o=1 for 1 cycle, new_pc_o=epc (bypassed value), flush_o=1, exc_we_o=0.
- Latency is 1 cycle from the detecting MEM cycle to the strobes, flush_o and new_pc_o.
- FSM:
  - IDLE: on event, go to FLUSH and load counter=FLUSH_CYCLES-1.
  - FLUSH: flush_o=1 and new_pc_o held stable. The counter decrements each cycle; at 0, go to IDLE with flush_o=0 on the following cycle.
  - All MEM inputs are ignored while in FLUSH, so no second event is captured.
- Strobes are exactly 1 cycle regardless of FLUSH_CYCLES. exc_code_o, exc_bd_o and exc_epc_o hold their values until the next event.
- Simultaneous events:
  - Interrupt and eret both qualify: the interrupt wins, and EPC = the eret's PC.
  - mem_valid_i=0: no event, even if an interrupt is pending. This prevents EPC being taken from a bubble.

Test Plan:
1. Reset, then int_raw_i=6'b000001 with status=32'h00000401 and cause[10]=1 at MEM pc=32'h100, mem_valid_i=1 -> int_o[0] rises 2 cycles after int_raw_i; next cycle exc_we_o=1, exc_code_o=0, exc_epc_o=32'h100, new_pc_o=32'h20, flush_o=1 for 1 cycle.
2. mem_syscall_i=1, mem_in_delay_i=1, pc=32'h204 -> exc_code_o=8, exc_bd_o=1, exc_epc_o=32'h200.
3. mem_eret_i=1, epc_i=32'h50, WB mtc0 to reg 14 with data 32'h80 in the same cycle -> eret_o=1, new_pc_o=32'h80, exc_we_o=0.
4. mem_ri_i=1 and mem_ov_i=1 together -> exc_code_o=10 only; with FLUSH_CYCLES=3, flush_o is high exactly 3 cycles and a syscall presented during the flush is ignored.
5. Interrupt pending with st[1]=1 (EXL) or st[0]=0, or with mem_valid_i=0 -> no exc_we_o and no flush_o.
6. rst asserted in the 2nd flush cycle (FLUSH_CYCLES=3) -> all outputs 0 at the next edge; int_o cleared; a syscall 1 cycle after rst deasserts is handled normally.
